// File: rtl/toggle_pulse_gen.sv
// Debounced push-button to single-cycle toggle request, plus a debounced level and a press counter.
// Latency DEBOUNCE_CYCLES+2 edges from btn_in to t_pulse or btn_level; no backpressure, outputs are free-running.
module toggle_pulse_gen #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_in,
   output logic       t_pulse,
   output logic       btn_level,
   output logic [7:0] press_count
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   logic             r_sync1;
   logic             r_sync2;
   logic             w_btn_s;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_accept;
   logic             w_level_nxt;
   logic             r_t_pulse;
   logic             r_btn_level;
   logic [7:0]       r_press_count;

   // Only the second synchronizer stage feeds any logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= btn_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_btn_s = r_sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_btn_s) begin
               w_state_nxt = PRESS_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!w_btn_s) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = PRESSED;
               w_accept    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!w_btn_s) begin
               w_state_nxt = RELEASE_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         RELEASE_WAIT: begin
            // A bounce back high resumes the held press without a new toggle.
            if (w_btn_s) begin
               w_state_nxt = PRESSED;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign w_level_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_t_pulse     <= 1'b0;
         r_btn_level   <= 1'b0;
         r_press_count <= 8'd0;
      end else begin
         r_t_pulse     <= w_accept;
         r_btn_level   <= w_level_nxt;
         r_press_count <= r_press_count + 8'(w_accept);
      end
   end

   assign t_pulse     = r_t_pulse;
   assign btn_level   = r_btn_level;
   assign press_count = r_press_count;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Directed bench for toggle_pulse_gen with DEBOUNCE_CYCLES=4; expected values are hand-derived edge counts.
module tb_toggle_pulse_gen;

   logic       clk;
   logic       rst_n;
   logic       btn_in;
   logic       t_pulse;
   logic       btn_level;
   logic [7:0] press_count;

   int n_total = 0;
   int n_bad   = 0;

   int   pulse_cnt = 0;
   int   dbl_cnt   = 0;
   int   hi_cyc    = 0;
   int   lo_cyc    = 0;
   logic prev_pulse = 1'b0;
   logic tff;

   int base_pulse;
   int base_hi;
   int base_lo;

   toggle_pulse_gen #(.DEBOUNCE_CYCLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_in      (btn_in),
      .t_pulse     (t_pulse),
      .btn_level   (btn_level),
      .press_count (press_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream toggle flip-flop driven by t_pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tff <= 1'b0;
      else if (t_pulse) tff <= ~tff;
   end

   always @(negedge clk) begin
      if (t_pulse) pulse_cnt++;
      if (t_pulse && prev_pulse) dbl_cnt++;
      prev_pulse = t_pulse;
      if (btn_level) hi_cyc++;
      else lo_cyc++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Called at a negedge with btn_in low; holds btn_in at val for n cycles.
   task automatic drive(input logic val, input int n);
      btn_in = val;
      repeat (n) @(negedge clk);
   endtask

   // Edge 0 is the first rising edge after btn_in is high; pulse after edge 6, level from edge 6.
   task automatic press_timing(input string tag, input logic set_btn);
      if (set_btn) btn_in = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check({tag, "_pulse"}, 32'(t_pulse), 32'(k == 6));
         check({tag, "_level"}, 32'(btn_level), 32'(k >= 6));
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      btn_in = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst_n  = 1'b0;
      btn_in = 1'b1;
      #12;
      check("rst_pulse", 32'(t_pulse), 32'd0);
      check("rst_level", 32'(btn_level), 32'd0);
      check("rst_count", 32'(press_count), 32'd0);
      check("rst_tff", 32'(tff), 32'd0);
      btn_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Clean press with exact edge timing, then release timing.
      press_timing("clean", 1'b1);
      check("clean_count", 32'(press_count), 32'd1);
      btn_in = 1'b0;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         check("release_level", 32'(btn_level), 32'(k < 6));
      end

      // Bounce: 3 high, 2 low, 3 high, then low never reaches acceptance.
      base_pulse = pulse_cnt;
      base_hi    = hi_cyc;
      drive(1'b1, 3);
      drive(1'b0, 2);
      drive(1'b1, 3);
      drive(1'b0, 10);
      check("bounce_pulses", 32'(pulse_cnt - base_pulse), 32'd0);
      check("bounce_level_hi_cycles", 32'(hi_cyc - base_hi), 32'd0);
      check("bounce_count", 32'(press_count), 32'd1);

      // Release glitch while pressed.
      drive(1'b1, 10);
      check("glitch_pre_count", 32'(press_count), 32'd2);
      base_pulse = pulse_cnt;
      base_lo    = lo_cyc;
      drive(1'b0, 2);
      drive(1'b1, 10);
      check("glitch_pulses", 32'(pulse_cnt - base_pulse), 32'd0);
      check("glitch_level_lo_cycles", 32'(lo_cyc - base_lo), 32'd0);
      check("glitch_level", 32'(btn_level), 32'd1);
      check("glitch_count", 32'(press_count), 32'd2);
      drive(1'b0, 10);

      // Asynchronous reset during the t_pulse cycle.
      btn_in = 1'b1;
      repeat (7) @(negedge clk);
      check("pre_rst_pulse", 32'(t_pulse), 32'd1);
      check("pre_rst_count", 32'(press_count), 32'd3);
      #1 rst_n = 1'b0;
      #1;
      check("arst_pulse", 32'(t_pulse), 32'd0);
      check("arst_level", 32'(btn_level), 32'd0);
      check("arst_count", 32'(press_count), 32'd0);
      btn_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Reset mid-debounce at edge 3 of a press; held level becomes a fresh press.
      btn_in = 1'b1;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_pulse", 32'(t_pulse), 32'd0);
      check("mid_rst_level", 32'(btn_level), 32'd0);
      check("mid_rst_count", 32'(press_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      base_pulse = pulse_cnt;
      press_timing("post_rst", 1'b0);
      drive(1'b1, 10);
      check("post_rst_pulses", 32'(pulse_cnt - base_pulse), 32'd1);
      check("post_rst_count", 32'(press_count), 32'd1);
      drive(1'b0, 10);

      // Downstream toggle flip-flop over 5 presses.
      do_reset();
      base_pulse = pulse_cnt;
      for (int p = 0; p < 5; p++) begin
         drive(1'b1, 9);
         drive(1'b0, 9);
      end
      check("tff_toggles", 32'(pulse_cnt - base_pulse), 32'd5);
      check("tff_out", 32'(tff), 32'd1);
      check("tff_count", 32'(press_count), 32'd5);

      // 256 presses wrap the counter back to zero.
      do_reset();
      base_pulse = pulse_cnt;
      for (int p = 0; p < 255; p++) begin
         drive(1'b1, 9);
         drive(1'b0, 9);
      end
      check("wrap_count_255", 32'(press_count), 32'd255);
      drive(1'b1, 9);
      drive(1'b0, 9);
      check("wrap_count_0", 32'(press_count), 32'd0);
      check("wrap_pulses", 32'(pulse_cnt - base_pulse), 32'd256);
      check("single_cycle_pulses", 32'(dbl_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
